// File: rtl/blft_pix_feeder.sv
// rtl/blft_pix_feeder.sv - raster-order pixel source for the bilateral filter core input
//
// Reads IMG_W*IMG_H pixels from an image memory in raster order and streams one
// pixel per cycle to the filter core, then waits for the core's finish flag.
//
// Ports:
//   clk, rst       clock / synchronous active-low reset
//   start          frame request, honoured only in IDLE
//   mem_rd_*       image memory read port (data returns MEM_LAT cycles after rd_en)
//   in_valid/addr/data   registered pixel stream into the filter core
//   finish         filter core completion flag
//   busy, done, err      status: active, end-of-operation pulse, sticky timeout
module blft_pix_feeder #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 9,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              in_valid,
    output logic [ADDR_W-1:0] in_addr,
    output logic [DATA_W-1:0] in_data,
    input  logic              finish,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                N         = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam int                TW        = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] rd_ptr;
    logic [MEM_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_a [MEM_LAT];
    logic [TW-1:0]     to_cnt;
    logic              fin_seen;

    // Equality compare on the last address so a full 2^ADDR_W frame never
    // depends on the pointer wrapping.
    logic last_rd;
    logic pipe_empty;
    logic timed_out;

    assign last_rd    = (rd_ptr == LAST_ADDR);
    assign pipe_empty = ~|pipe_v;
    assign timed_out  = (to_cnt == TO_LAST);
    assign mem_rd_addr = mem_rd_en ? rd_ptr : '0;

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                if (last_rd) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Pipeline empty while the final pixel is on the outputs.
                if (pipe_empty && in_valid) state_nxt = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                busy = 1'b1;
                if (finish || fin_seen || timed_out) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            pipe_v   <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe_a[i] <= '0;
            in_valid <= 1'b0;
            in_addr  <= '0;
            in_data  <= '0;
            to_cnt   <= '0;
            fin_seen <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Valid/address travel alongside each read so the returning data
            // is tagged with the address it was fetched from.
            pipe_v[0] <= mem_rd_en;
            pipe_a[0] <= rd_ptr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            in_valid <= pipe_v[MEM_LAT-1];
            if (pipe_v[MEM_LAT-1]) begin
                in_addr <= pipe_a[MEM_LAT-1];
                in_data <= mem_rd_data;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_ptr   <= '0;
                        err      <= 1'b0;
                        fin_seen <= 1'b0;
                        to_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    rd_ptr <= rd_ptr + 1'b1;
                    if (finish) fin_seen <= 1'b1;
                end
                S_DRAIN: begin
                    if (finish) fin_seen <= 1'b1;
                end
                S_WAIT_FIN: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (!finish && !fin_seen && timed_out) err <= 1'b1;
                end
                S_DONE: begin
                    fin_seen <= 1'b0;
                    to_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blft_pix_feeder.sv
// tb/tb_blft_pix_feeder.sv - directed self-checking bench for blft_pix_feeder
module tb_blft_pix_feeder;

    logic clk;
    logic rst;

    // Instance A: 4x2, MEM_LAT=1.  B: 4x2, MEM_LAT=3.  C: 4x4 on a 4-bit address (N = 2^ADDR_W), MEM_LAT=2.
    logic        start_a, start_b, start_c;
    logic        finish_a, finish_b, finish_c;
    logic        rd_en_a, rd_en_b, rd_en_c;
    logic [15:0] rd_addr_a, rd_addr_b;
    logic [3:0]  rd_addr_c;
    logic [8:0]  rd_data_a, rd_data_b, rd_data_c;
    logic        iv_a, iv_b, iv_c;
    logic [15:0] ia_a, ia_b;
    logic [3:0]  ia_c;
    logic [8:0]  id_a, id_b, id_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        err_a, err_b, err_c;

    blft_pix_feeder #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .DATA_W(9), .MEM_LAT(1), .TIMEOUT(16)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a),
        .mem_rd_data(rd_data_a), .in_valid(iv_a), .in_addr(ia_a), .in_data(id_a),
        .finish(finish_a), .busy(busy_a), .done(done_a), .err(err_a));

    blft_pix_feeder #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .DATA_W(9), .MEM_LAT(3), .TIMEOUT(16)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b),
        .mem_rd_data(rd_data_b), .in_valid(iv_b), .in_addr(ia_b), .in_data(id_b),
        .finish(finish_b), .busy(busy_b), .done(done_b), .err(err_b));

    blft_pix_feeder #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .DATA_W(9), .MEM_LAT(2), .TIMEOUT(16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mem_rd_en(rd_en_c), .mem_rd_addr(rd_addr_c),
        .mem_rd_data(rd_data_c), .in_valid(iv_c), .in_addr(ia_c), .in_data(id_c),
        .finish(finish_c), .busy(busy_c), .done(done_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memories: A/B hold addr*3, C holds addr*3+1; 0x1AA when no read is issued.
    logic [8:0] dl_b [3];
    logic [8:0] dl_c [2];
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? 9'(rd_addr_a * 3) : 9'h1AA;
        dl_b[0]   <= rd_en_b ? 9'(rd_addr_b * 3) : 9'h1AA;
        dl_b[1]   <= dl_b[0];
        dl_b[2]   <= dl_b[1];
        dl_c[0]   <= rd_en_c ? 9'({5'b0, rd_addr_c} * 3 + 1) : 9'h1AA;
        dl_c[1]   <= dl_c[0];
    end
    assign rd_data_b = dl_b[2];
    assign rd_data_c = dl_c[1];

    logic        s_rd [3];
    logic        s_v  [3];
    logic        s_dn [3];
    logic        s_er [3];
    logic        s_bz [3];
    logic [15:0] s_ia [3];
    logic [8:0]  s_id [3];
    assign s_rd[0] = rd_en_a; assign s_rd[1] = rd_en_b; assign s_rd[2] = rd_en_c;
    assign s_v[0]  = iv_a;    assign s_v[1]  = iv_b;    assign s_v[2]  = iv_c;
    assign s_dn[0] = done_a;  assign s_dn[1] = done_b;  assign s_dn[2] = done_c;
    assign s_er[0] = err_a;   assign s_er[1] = err_b;   assign s_er[2] = err_c;
    assign s_bz[0] = busy_a;  assign s_bz[1] = busy_b;  assign s_bz[2] = busy_c;
    assign s_ia[0] = ia_a;    assign s_ia[1] = ia_b;    assign s_ia[2] = {12'b0, ia_c};
    assign s_id[0] = id_a;    assign s_id[1] = id_b;    assign s_id[2] = id_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int first_rd [3], first_v [3], last_v [3], rd_cnt [3], vcnt [3];
    int bad_seq [3], bad_data [3], gaps [3], bad_rd [3], done_cnt [3], done_cyc [3];
    int first_ia [3], last_ia [3];
    logic [15:0] exp_a [3];
    logic saw_last [3], err_at_done [3], busy_at_done [3];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pix(input int k, input logic [15:0] a);
        return (k == 2) ? 9'(a * 3 + 1) : 9'(a * 3);
    endfunction

    function automatic int last_addr(input int k);
        return (k == 2) ? 15 : 7;
    endfunction

    task automatic clear(input int k);
        first_rd[k] = -1; first_v[k] = -1; last_v[k] = -1; rd_cnt[k] = 0; vcnt[k] = 0;
        bad_seq[k] = 0; bad_data[k] = 0; gaps[k] = 0; bad_rd[k] = 0; done_cnt[k] = 0;
        done_cyc[k] = -1; first_ia[k] = -1; last_ia[k] = -1; exp_a[k] = 16'd0;
        saw_last[k] = 1'b0; err_at_done[k] = 1'b0; busy_at_done[k] = 1'b1;
    endtask

    // Advance one clock and sample all outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (s_rd[k]) begin
                if (first_rd[k] < 0) first_rd[k] = cyc;
                if (saw_last[k]) bad_rd[k]++;
                rd_cnt[k]++;
                if (k == 0 && int'(rd_addr_a) == last_addr(0)) saw_last[k] = 1'b1;
                if (k == 1 && int'(rd_addr_b) == last_addr(1)) saw_last[k] = 1'b1;
                if (k == 2 && int'(rd_addr_c) == last_addr(2)) saw_last[k] = 1'b1;
            end
            if (s_v[k]) begin
                if (first_v[k] < 0) begin
                    first_v[k]  = cyc;
                    first_ia[k] = int'(s_ia[k]);
                end
                if (last_v[k] >= 0 && last_v[k] != cyc - 1) gaps[k]++;
                if (s_ia[k] != exp_a[k]) bad_seq[k]++;
                if (s_id[k] != pix(k, s_ia[k])) bad_data[k]++;
                exp_a[k]   = s_ia[k] + 16'd1;
                last_v[k]  = cyc;
                last_ia[k] = int'(s_ia[k]);
                vcnt[k]++;
            end
            if (s_dn[k]) begin
                done_cnt[k]++;
                done_cyc[k]     = cyc;
                err_at_done[k]  = s_er[k];
                busy_at_done[k] = s_bz[k];
            end
        end
    endtask

    task automatic pulse(input int k);
        if (k == 0) start_a = 1'b1;
        if (k == 1) start_b = 1'b1;
        if (k == 2) start_c = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (done_cnt[k] == 0 && n < budget) begin
            step();
            n++;
        end
        check_eq($sformatf("done_seen%0d", k), done_cnt[k], 1);
        repeat (4) step();
        check_eq($sformatf("done_once%0d", k), done_cnt[k], 1);
        check_eq($sformatf("busy_at_done%0d", k), busy_at_done[k], 0);
    endtask

    task automatic frame_checks(input int k, input int n, input int lat);
        check_eq($sformatf("rd_cnt%0d", k), rd_cnt[k], n);
        check_eq($sformatf("beats%0d", k), vcnt[k], n);
        check_eq($sformatf("lead%0d", k), first_v[k] - first_rd[k], lat + 1);
        check_eq($sformatf("span%0d", k), last_v[k] - first_rd[k], n + lat);
        check_eq($sformatf("first_addr%0d", k), first_ia[k], 0);
        check_eq($sformatf("last_addr%0d", k), last_ia[k], n - 1);
        check_eq($sformatf("addr_seq%0d", k), bad_seq[k], 0);
        check_eq($sformatf("data%0d", k), bad_data[k], 0);
        check_eq($sformatf("gaps%0d", k), gaps[k], 0);
        check_eq($sformatf("rd_after_last%0d", k), bad_rd[k], 0);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        finish_a = 1'b0; finish_b = 1'b0; finish_c = 1'b0;
        for (int k = 0; k < 3; k++) clear(k);
        repeat (3) step();

        check_eq("rst_in_valid", iv_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_rd_en", rd_en_a, 0);
        check_eq("rst_err", err_a, 0);
        check_eq("rst_in_addr", ia_a, 0);
        check_eq("rst_in_data", id_a, 0);
        check_eq("rst_busy_c", busy_c, 0);

        rst = 1'b1;
        step();

        // A: 8-pixel frame, latency 1, finish already high.
        finish_a = 1'b1;
        clear(0);
        pulse(0);
        wait_done(0, 100);
        frame_checks(0, 8, 1);
        check_eq("early_fin_a", done_cyc[0] - last_v[0], 2);
        check_eq("err_a_ok", err_at_done[0], 0);

        // B: latency 3, finish high from the start, second start during FETCH ignored.
        finish_b = 1'b1;
        clear(1);
        pulse(1);
        step();
        pulse(1);
        wait_done(1, 100);
        frame_checks(1, 8, 3);
        check_eq("early_fin_b", done_cyc[1] - last_v[1], 2);
        check_eq("err_b_ok", err_at_done[1], 0);

        // C: N = 2^ADDR_W, last address all-ones with no wrap back to 0.
        finish_c = 1'b1;
        clear(2);
        pulse(2);
        wait_done(2, 100);
        frame_checks(2, 16, 2);

        // A: timeout with finish never asserted.
        finish_a = 1'b0;
        clear(0);
        pulse(0);
        wait_done(0, 200);
        frame_checks(0, 8, 1);
        check_eq("timeout_gap", done_cyc[0] - last_v[0], 17);
        check_eq("timeout_err", err_at_done[0], 1);
        check_eq("err_sticky", err_a, 1);
        finish_a = 1'b1;
        clear(0);
        pulse(0);
        check_eq("err_cleared", err_a, 0);
        wait_done(0, 100);
        frame_checks(0, 8, 1);

        // A: reset while pixel 5 is presented, then a clean frame.
        clear(0);
        pulse(0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (iv_a && ia_a == 16'd5) found = 1'b1;
            else step();
        end
        check_eq("pix5_seen", found, 1);
        rst = 1'b0;
        step();
        check_eq("abort_in_valid", iv_a, 0);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_rd_en", rd_en_a, 0);
        rst = 1'b1;
        step();
        clear(0);
        pulse(0);
        wait_done(0, 100);
        frame_checks(0, 8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
